// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants and types for the fetch PC controller: branch flag encoding,
// reset/exception vectors, default step, FSM state and next-pc source encodings.
package pc_fetch_ctrl_pkg;

   localparam logic BRANCH     = 1'b1;
   localparam logic NOT_BRANCH = 1'b0;

   localparam logic [31:0] DEFAULT_RESET_VEC = 32'hBFC0_0000;
   localparam logic [31:0] EXC_VEC_BOOT      = 32'hBFC0_0380;
   localparam logic [31:0] EXC_VEC_NORMAL    = 32'h8000_0180;
   localparam int unsigned DEFAULT_STEP      = 4;

   // run and pend_valid are folded into one state: RESET means run=0,
   // PENDING means a branch target is being held for the next advance.
   typedef enum logic [1:0] {
      ST_RESET   = 2'd0,
      ST_FETCH   = 2'd1,
      ST_PENDING = 2'd2
   } fetch_state_e;

   typedef enum logic [2:0] {
      SEL_HOLD   = 3'd0,
      SEL_FLUSH  = 3'd1,
      SEL_PEND   = 3'd2,
      SEL_BRANCH = 3'd3,
      SEL_STEP   = 3'd4
   } next_sel_e;

   function automatic logic is_misaligned(input logic [1:0] lsb);
      return |lsb;
   endfunction

endpackage

// File: rtl/pc_fetch_ctrl_pc_next_sel.sv
// Combinational next-pc priority mux: flush, held branch, live branch, step, hold.
// Also produces the pending-branch load/clear controls.
module pc_next_sel
   import pc_fetch_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned STEP   = DEFAULT_STEP
) (
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_addr,
   input  logic              adv,
   input  logic              pend_valid,
   input  logic [ADDR_W-1:0] pend_addr,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_addr,
   input  logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] next_pc,
   output logic              pc_update,
   output logic              pend_load,
   output logic              pend_clr,
   output next_sel_e         sel
);

   logic branch_taken;

   assign branch_taken = (branch_flag == BRANCH);

   // A branch that cannot be taken now is captured only when nothing is
   // already held; later branches are dropped until the held one is used.
   always_comb begin
      sel       = SEL_HOLD;
      next_pc   = pc;
      pc_update = 1'b0;
      pend_load = 1'b0;
      pend_clr  = 1'b0;
      if (flush) begin
         sel       = SEL_FLUSH;
         next_pc   = flush_addr;
         pc_update = 1'b1;
         pend_clr  = 1'b1;
      end else if (adv && pend_valid) begin
         sel       = SEL_PEND;
         next_pc   = pend_addr;
         pc_update = 1'b1;
         pend_clr  = 1'b1;
      end else if (adv && branch_taken) begin
         sel       = SEL_BRANCH;
         next_pc   = branch_addr;
         pc_update = 1'b1;
      end else if (adv) begin
         sel       = SEL_STEP;
         next_pc   = pc + ADDR_W'(STEP);
         pc_update = 1'b1;
      end else if (branch_taken && !pend_valid) begin
         pend_load = 1'b1;
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch program-counter controller with imem request/ack handshake, stall,
// held branch redirect and flush. Optional alignment check: PC_ALIGN_CHECK_EN.
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
   parameter int unsigned STEP      = DEFAULT_STEP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_addr,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_addr,
   input  logic              if_ack,
   output logic [ADDR_W-1:0] pc,
   output logic              if_req,
   output logic              addr_err
);

   localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC);

   fetch_state_e      state;
   logic              run;
   logic              pend_valid;
   logic [ADDR_W-1:0] pend_addr;
   logic              adv;
   logic [ADDR_W-1:0] next_pc;
   logic              pc_update;
   logic              pend_load;
   logic              pend_clr;
   next_sel_e         sel;

   assign run        = (state != ST_RESET);
   assign pend_valid = (state == ST_PENDING);
   assign if_req     = run & ~stall & ~addr_err;
   assign adv        = if_req & if_ack;

   pc_next_sel #(
      .ADDR_W (ADDR_W),
      .STEP   (STEP)
   ) u_next_sel (
      .flush       (flush),
      .flush_addr  (flush_addr),
      .adv         (adv),
      .pend_valid  (pend_valid),
      .pend_addr   (pend_addr),
      .branch_flag (branch_flag),
      .branch_addr (branch_addr),
      .pc          (pc),
      .next_pc     (next_pc),
      .pc_update   (pc_update),
      .pend_load   (pend_load),
      .pend_clr    (pend_clr),
      .sel         (sel)
   );

   // A flush always lands in FETCH, including straight out of RESET.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_RESET;
         pc        <= RESET_PC;
         pend_addr <= '0;
      end else begin
         if (pc_update) begin
            pc <= next_pc;
         end
         if (pend_load) begin
            pend_addr <= branch_addr;
         end
         unique case (state)
            ST_RESET:   state <= pend_load ? ST_PENDING : ST_FETCH;
            ST_FETCH:   if (pend_load) state <= ST_PENDING;
            ST_PENDING: if (pend_clr) state <= ST_FETCH;
            default:    state <= ST_RESET;
         endcase
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   logic addr_err_q;
   logic step_sel;

   assign step_sel = (sel != SEL_HOLD) && (sel != SEL_FLUSH);

   // Only a flush clears the error; while it is set if_req is low so pc holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_err_q <= 1'b0;
      end else if (flush) begin
         addr_err_q <= 1'b0;
      end else if (step_sel && is_misaligned(next_pc[1:0])) begin
         addr_err_q <= 1'b1;
      end
   end

   assign addr_err = addr_err_q;
`else
   assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed test-plan sequence then random
// traffic, checked against a queue-based reference model.
module tb_pc_fetch_ctrl;
   import pc_fetch_ctrl_pkg::*;

   localparam logic [31:0] RV     = 32'hBFC0_0000;
   localparam logic [31:0] STEP_C = 32'd4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        branch_flag = NOT_BRANCH;
   logic [31:0] branch_addr = '0;
   logic        flush = 1'b0;
   logic [31:0] flush_addr = '0;
   logic        if_ack = 1'b0;
   logic [31:0] pc;
   logic        if_req;
   logic        addr_err;

   always #5 clk = ~clk;

   pc_fetch_ctrl #(
      .ADDR_W    (32),
      .RESET_VEC (RV),
      .STEP      (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .branch_flag (branch_flag),
      .branch_addr (branch_addr),
      .flush       (flush),
      .flush_addr  (flush_addr),
      .if_ack      (if_ack),
      .pc          (pc),
      .if_req      (if_req),
      .addr_err    (addr_err)
   );

   typedef struct {
      logic [31:0] pc;
      logic        req;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_pc = RV;
   bit          m_run = 1'b0;
   bit          m_err = 1'b0;
   logic [31:0] m_pend[$];
   int          n_vec = 0;
   int          n_err = 0;

   // Drive one cycle of inputs, record what the DUT must show during this
   // cycle, then advance the model across the coming rising edge.
   task automatic applyStimulus(input logic r, input logic s, input logic bf,
                                input logic [31:0] ba, input logic f,
                                input logic [31:0] fa, input logic a);
      exp_t e;
      bit   adv;
      @(negedge clk);
      rst = r; stall = s; branch_flag = bf; branch_addr = ba;
      flush = f; flush_addr = fa; if_ack = a;
      if (!r) begin
         m_pc = RV; m_run = 1'b0; m_err = 1'b0; m_pend.delete();
         e.pc = RV; e.req = 1'b0; e.err = 1'b0;
         exp_q.push_back(e);
      end else begin
         e.pc  = m_pc;
         e.req = m_run && !s && !m_err;
         e.err = m_err;
         exp_q.push_back(e);
         adv = e.req && a;
         if (f) begin
            m_pc  = fa;
            m_err = 1'b0;
            m_pend.delete();
         end else if (adv) begin
            if (m_pend.size() > 0) m_pc = m_pend.pop_front();
            else if (bf == BRANCH) m_pc = ba;
            else m_pc = m_pc + STEP_C;
`ifdef PC_ALIGN_CHECK_EN
            if (m_pc[1:0] != 2'b00) m_err = 1'b1;
`endif
         end else if (bf == BRANCH && m_pend.size() == 0) begin
            m_pend.push_back(ba);
         end
         m_run = 1'b1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("pc", pc, e.pc);
            checkOutput("if_req", {31'b0, if_req}, {31'b0, e.req});
            checkOutput("addr_err", {31'b0, addr_err}, {31'b0, e.err});
         end
      end
   end

   initial begin : stimulus
      logic        r, s, bf, f, a;
      logic [31:0] ba, fa;

      $display("[TB] reset and sequential fetch");
      repeat (3) applyStimulus(0, 0, NOT_BRANCH, 0, 0, 0, 1);
      repeat (3) applyStimulus(1, 0, NOT_BRANCH, 0, 0, 0, 1);

      $display("[TB] stall at BFC00008");
      repeat (2) applyStimulus(1, 1, NOT_BRANCH, 0, 0, 0, 1);
      repeat (2) applyStimulus(1, 0, NOT_BRANCH, 0, 0, 0, 1);

      $display("[TB] branch held while ack low, second branch dropped");
      applyStimulus(1, 0, BRANCH, 32'h8000_1000, 0, 0, 0);
      applyStimulus(1, 0, BRANCH, 32'h8000_2000, 0, 0, 0);
      repeat (3) applyStimulus(1, 0, NOT_BRANCH, 0, 0, 0, 1);

      $display("[TB] flush priority over pending branch and stall");
      applyStimulus(1, 0, BRANCH, 32'h8000_3000, 0, 0, 0);
      applyStimulus(1, 1, BRANCH, 32'h8000_4000, 1, EXC_VEC_BOOT, 0);
      repeat (3) applyStimulus(1, 0, NOT_BRANCH, 0, 0, 0, 1);

      $display("[TB] wrap-around");
      applyStimulus(1, 0, NOT_BRANCH, 0, 1, 32'hFFFF_FFFC, 0);
      repeat (3) applyStimulus(1, 0, NOT_BRANCH, 0, 0, 0, 1);

`ifdef PC_ALIGN_CHECK_EN
      $display("[TB] alignment check");
      applyStimulus(1, 0, BRANCH, 32'h8000_1002, 0, 0, 1);
      repeat (3) applyStimulus(1, 0, NOT_BRANCH, 0, 0, 0, 1);
      applyStimulus(1, 0, NOT_BRANCH, 0, 1, EXC_VEC_BOOT, 1);
      repeat (2) applyStimulus(1, 0, NOT_BRANCH, 0, 0, 0, 1);
`endif

      $display("[TB] random traffic");
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 99) != 0);
         s  = ($urandom_range(0, 3) == 0);
         bf = ($urandom_range(0, 3) == 0) ? BRANCH : NOT_BRANCH;
         f  = ($urandom_range(0, 15) == 0);
         a  = ($urandom_range(0, 2) != 0);
         ba = $urandom & 32'hFFFF_FFFC;
         fa = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 31) == 0) fa = 32'hFFFF_FFFC;
`ifdef PC_ALIGN_CHECK_EN
         if ($urandom_range(0, 15) == 0) ba = $urandom;
`endif
         applyStimulus(r, s, bf, ba, f, fa, a);
      end
      applyStimulus(1, 0, NOT_BRANCH, 0, 0, 0, 1);

      repeat (2) @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("[TB] FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
